// File: rtl/spi_tx_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_tx_feeder: byte FIFO and frame sequencer feeding an SPI master |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_tx_feeder #(
   parameter int DEPTH         = 8,
   parameter int ADDR_W        = 3,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              cs_in,
   output logic              tx_enable,
   output logic [7:0]        din,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              busy,
   output logic              overflow,
   output logic              start_err,
   output logic [7:0]        frames_sent
);

   localparam int c_TMR_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
   localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
   localparam logic [c_TMR_W-1:0] c_START_LAST = c_TMR_W'(START_TIMEOUT - 1);
   localparam logic [c_TMR_W-1:0] c_GAP_LAST   = c_TMR_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD       = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_END   = 3'd3,
      S_GAP        = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_TMR_W-1:0]  r_timer;
   logic                r_tx_enable;
   logic [7:0]          r_din;
   logic                r_start_err;
   logic [7:0]          r_frames;

   logic [7:0]          r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W:0]     r_level;
   logic                r_full;
   logic                r_empty;
   logic                r_overflow;

   logic                r_cs_meta;
   logic                r_cs_sync;
   logic                r_cs_prev;

   logic                w_push;
   logic                w_pop;
   logic [ADDR_W:0]     w_level_nxt;
   logic                w_cs_fall;
   logic                w_cs_rise;

   // Preset to 1 (idle cs) so releasing reset never fakes a frame edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cs_meta <= 1'b1;
         r_cs_sync <= 1'b1;
         r_cs_prev <= 1'b1;
      end else begin
         r_cs_meta <= cs_in;
         r_cs_sync <= r_cs_meta;
         r_cs_prev <= r_cs_sync;
      end
   end

   assign w_cs_fall   = r_cs_prev & ~r_cs_sync;
   assign w_cs_rise   = ~r_cs_prev & r_cs_sync;

   assign w_push      = wr_en & ~r_full;
   assign w_pop       = (r_state == S_LOAD);
   assign w_level_nxt = r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == (ADDR_W+1)'(DEPTH));
         r_empty <= (w_level_nxt == '0);
         if (wr_en && r_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_tx_enable <= 1'b0;
         r_din       <= 8'h00;
         r_start_err <= 1'b0;
         r_frames    <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx_enable <= 1'b0;
               if (!r_empty) begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_din       <= r_mem[r_rd_ptr];
               r_tx_enable <= 1'b1;
               r_timer     <= '0;
               r_state     <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (w_cs_fall) begin
                  r_state <= S_WAIT_END;
               end else if (r_timer == c_START_LAST) begin
                  // Master never answered: drop this byte and move on.
                  r_start_err <= 1'b1;
                  r_tx_enable <= 1'b0;
                  r_timer     <= '0;
                  r_state     <= S_GAP;
               end else begin
                  r_timer <= r_timer + c_TMR_W'(1);
               end
            end
            S_WAIT_END: begin
               if (w_cs_rise) begin
                  r_frames    <= r_frames + 8'd1;
                  r_tx_enable <= 1'b0;
                  r_timer     <= '0;
                  r_state     <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_timer == c_GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_timer <= r_timer + c_TMR_W'(1);
               end
            end
            default: begin
               r_tx_enable <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_enable   = r_tx_enable;
   assign din         = r_din;
   assign full        = r_full;
   assign empty       = r_empty;
   assign level       = r_level;
   assign busy        = (r_state != S_IDLE);
   assign overflow    = r_overflow;
   assign start_err   = r_start_err;
   assign frames_sent = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_feeder.sv
`default_nettype none
// Bench for spi_tx_feeder: random host writes and a behavioural SPI master,
// with a FIFO-order scoreboard checked whenever a frame is requested.
module tb_spi_tx_feeder;

   localparam int DEPTH         = 8;
   localparam int ADDR_W        = 3;
   localparam int GAP_CYCLES    = 16;
   localparam int START_TIMEOUT = 256;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en;
   logic [7:0]      wr_data;
   logic            cs_in;
   logic            tx_enable;
   logic [7:0]      din;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] level;
   logic            busy;
   logic            overflow;
   logic            start_err;
   logic [7:0]      frames_sent;

   spi_tx_feeder #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES), .START_TIMEOUT(START_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .cs_in(cs_in),
      .tx_enable(tx_enable), .din(din), .full(full), .empty(empty), .level(level),
      .busy(busy), .overflow(overflow), .start_err(start_err), .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q[$];
   int          n_acc = 0;
   int          n_pops = 0;
   logic        exp_overflow = 1'b0;
   logic        exp_start_err = 1'b0;
   logic [7:0]  exp_frames = 8'h00;
   bit          mon_en = 1'b0;
   bit          frame_had_cs = 1'b0;
   bit          master_on = 1'b1;
   bit          m_rand = 1'b0;
   bit          cs_toggle = 1'b0;
   int          m_delay = 20;
   int          m_hold = 40;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic issue_write(input logic [7:0] b);
      if (n_acc - n_pops >= DEPTH) begin
         exp_overflow = 1'b1;
      end else begin
         exp_q.push_back(b);
         n_acc++;
      end
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int i = 0;
      while (!(exp_q.size() == 0 && !busy && !tx_enable) && i < limit) begin
         @(negedge clk);
         i++;
      end
      if (i >= limit) fail_bound("drain_timeout");
   endtask

   task automatic wait_frame_active(input int limit);
      int i = 0;
      while (!(tx_enable && frame_had_cs) && i < limit) begin
         @(negedge clk);
         i++;
      end
      if (i >= limit) fail_bound("frame_start_timeout");
   endtask

   // Behavioural SPI master: answers each tx_enable rise with one cs frame.
   initial begin
      bit m_served = 1'b0;
      int d, h, lat;
      cs_in = 1'b1;
      forever begin
         @(negedge clk);
         if (cs_toggle) begin
            cs_in = ~cs_in;
         end else if (tx_enable && !m_served) begin
            m_served = 1'b1;
            if (master_on) begin
               d = m_rand ? int'($urandom_range(1, 60)) : m_delay;
               h = m_rand ? int'($urandom_range(1, 40)) : m_hold;
               repeat (d) @(negedge clk);
               cs_in = 1'b0;
               frame_had_cs = 1'b1;
               repeat (h) @(negedge clk);
               cs_in = 1'b1;
               if (tx_enable && rst) begin
                  lat = 0;
                  while (tx_enable && lat < 10) begin
                     @(posedge clk);
                     #1;
                     lat++;
                  end
                  check("cs_rise_to_tx_low", lat, 3);
               end
            end
         end else if (!tx_enable) begin
            cs_in = 1'b1;
         end
         if (!tx_enable) m_served = 1'b0;
      end
   end

   // Monitor: every frame request pops the scoreboard; flags checked each cycle.
   initial begin
      logic       prev_tx = 1'b0;
      logic [7:0] prev_din = 8'h00;
      int         high_cnt = 0;
      int         low_cnt = 0;
      bit         seen_fall = 1'b0;
      bit         rise, fall;
      forever begin
         @(posedge clk);
         #1;
         if (!mon_en) begin
            prev_tx   = 1'b0;
            prev_din  = din;
            seen_fall = 1'b0;
         end else begin
            rise = tx_enable && !prev_tx;
            fall = !tx_enable && prev_tx;
            if (rise) begin
               n_pops++;
               high_cnt = 1;
               if (exp_q.size() == 0) fail_bound("din_unexpected_frame");
               else check("din_frame_byte", din, exp_q.pop_front());
               if (seen_fall) begin
                  n_cmp++;
                  if (low_cnt < GAP_CYCLES + 2) begin
                     n_bad++;
                     $display("FAIL gap_len: got %0d cycles low, required >= %0d", low_cnt, GAP_CYCLES + 2);
                  end
               end
               frame_had_cs = 1'b0;
            end else begin
               if (tx_enable) high_cnt++;
               check("din_held", din, prev_din);
            end
            if (fall) begin
               if (frame_had_cs) begin
                  exp_frames++;
               end else begin
                  exp_start_err = 1'b1;
                  check("start_timeout_len", high_cnt, START_TIMEOUT);
               end
               low_cnt   = 1;
               seen_fall = 1'b1;
            end else if (!tx_enable) begin
               low_cnt++;
            end
            check("level", level, n_acc - n_pops);
            check("empty", empty, (n_acc == n_pops));
            check("full", full, (n_acc - n_pops == DEPTH));
            check("overflow", overflow, exp_overflow);
            check("start_err", start_err, exp_start_err);
            check("frames_sent", frames_sent, exp_frames);
            if (tx_enable) check("busy_in_frame", busy, 1);
            prev_tx  = tx_enable;
            prev_din = din;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] saved_frames;
      bit         pb;
      int         i;

      // Reset held with write strobe and cs activity
      rst = 1'b0; wr_en = 1'b1; wr_data = 8'hEE; cs_toggle = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_tx_enable", tx_enable, 0);
      check("rst_din", din, 8'h00);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_level", level, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_start_err", start_err, 0);
      check("rst_frames", frames_sent, 0);
      wr_en = 1'b0; cs_toggle = 1'b0;
      @(negedge clk);
      rst = 1'b1; mon_en = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_tx", tx_enable, 0);

      // Single byte
      m_delay = 20; m_hold = 40;
      issue_write(8'hA5);
      wait_idle(500);
      check("single_frames", frames_sent, 1);
      check("single_empty", empty, 1);

      // Fill during a long frame, then overflow
      m_delay = 2; m_hold = 200;
      @(negedge clk);
      issue_write(8'hFF);
      wait_frame_active(100);
      m_hold = 10;
      for (int b = 1; b <= 9; b++) issue_write(8'(b));
      check("fill_full", full, 1);
      check("fill_level", level, 8);
      check("fill_overflow", overflow, 1);
      wait_idle(3000);
      check("burst_frames", frames_sent, 10);

      // Write coinciding with a pop
      m_delay = 5; m_hold = 100;
      @(negedge clk);
      issue_write(8'h77);
      wait_frame_active(100);
      m_hold = 10;
      issue_write(8'hC1); issue_write(8'hC2); issue_write(8'hC3);
      pb = busy; i = 0;
      while (!(busy && !tx_enable && !pb) && i < 500) begin
         pb = busy;
         @(negedge clk);
         i++;
      end
      if (i >= 500) fail_bound("load_cycle_wait");
      issue_write(8'hC4);
      check("simul_level", level, 3);
      wait_idle(2000);

      // Start timeout, then recovery
      saved_frames = exp_frames;
      master_on = 1'b0;
      @(negedge clk);
      issue_write(8'h3C);
      i = 0;
      while (!start_err && i < 600) begin @(negedge clk); i++; end
      if (i >= 600) fail_bound("start_err_wait");
      check("timeout_tx_low", tx_enable, 0);
      wait_idle(200);
      check("timeout_frames", frames_sent, saved_frames);
      master_on = 1'b1; m_delay = 20; m_hold = 40;
      @(negedge clk);
      issue_write(8'h55);
      wait_idle(500);
      check("recover_frames", frames_sent, saved_frames + 8'd1);

      // Randomised traffic
      m_rand = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 25)) @(negedge clk);
         issue_write(8'($urandom));
      end
      wait_idle(20000);
      m_rand = 1'b0;

      // Reset in the middle of a frame with bytes queued
      m_delay = 5; m_hold = 150;
      @(negedge clk);
      issue_write(8'h11);
      wait_frame_active(100);
      issue_write(8'h22); issue_write(8'h33); issue_write(8'h44);
      repeat (5) @(negedge clk);
      #2;
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst_tx_enable", tx_enable, 0);
      check("midrst_level", level, 0);
      check("midrst_busy", busy, 0);
      exp_q.delete();
      n_acc = 0; n_pops = 0;
      exp_overflow = 1'b0; exp_start_err = 1'b0; exp_frames = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b1; mon_en = 1'b1;
      i = 0;
      while (!cs_in && i < 300) begin @(negedge clk); i++; end
      if (i >= 300) fail_bound("master_release_wait");
      repeat (8) @(negedge clk);
      check("midrst_frames", frames_sent, 0);
      check("midrst_empty", empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
